// File: rtl/uart_alu_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_alu_frame_ctrl
//
// Frame controller sitting between the UART RX/TX FIFOs and a combinational ALU.
// A frame is an opcode byte followed by operand A and operand B, each NB_AB bits
// wide and sent MSB byte first. The frame is gathered into shadow registers,
// committed to the ALU operand outputs in one step, and the ALU result is then
// pushed back to the TX FIFO, MSB byte first.
//
// Optional feature (compile-time macro UART_ALU_CHECKSUM_EN):
//   RX frames carry a trailing XOR checksum byte, which is verified before the
//   commit. A checksum byte (XOR of the result bytes) is appended on TX.
//   Without the macro, no checksum byte exists on either side.
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   rx_empty     RX FIFO empty
//   rx_data      RX FIFO head word (valid while !rx_empty)
//   rx_rd        RX FIFO pop strobe (one-cycle pulse)
//   tx_full      TX FIFO full
//   tx_data      TX FIFO write data
//   tx_wr        TX FIFO push strobe (one-cycle pulse)
//   o_op         committed opcode to the ALU
//   o_a, o_b     committed operands to the ALU
//   i_result     ALU result, combinational from o_op/o_a/o_b
//   o_busy       high whenever the controller is not idle
//   o_frame_err  one-cycle pulse on inter-byte timeout or checksum error
//   o_frame_cnt  count of transmitted frames, wraps 255 -> 0
// -----------------------------------------------------------------------------
module uart_alu_frame_ctrl #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int NB_AB   = 16,
    parameter int TIMEOUT = 50000,
    parameter int NB_TO   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx_empty,
    input  logic [DBIT-1:0]  rx_data,
    output logic             rx_rd,
    input  logic             tx_full,
    output logic [DBIT-1:0]  tx_data,
    output logic             tx_wr,
    output logic [NB_OP-1:0] o_op,
    output logic [NB_AB-1:0] o_a,
    output logic [NB_AB-1:0] o_b,
    input  logic [NB_AB-1:0] i_result,
    output logic             o_busy,
    output logic             o_frame_err,
    output logic [7:0]       o_frame_cnt
);

    localparam int NBYTE = NB_AB / DBIT;
`ifdef UART_ALU_CHECKSUM_EN
    localparam int NCHK = 1;
`else
    localparam int NCHK = 0;
`endif
    localparam int NRX     = 1 + 2 * NBYTE + NCHK;  // bytes per RX frame
    localparam int NTX     = NBYTE + NCHK;          // bytes per TX frame
    localparam int NB_TXSH = NTX * DBIT;
    localparam int RXW     = $clog2(NRX + 1);
    localparam int TXW     = $clog2(NTX + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RX   = 2'd1,
        S_EXEC = 2'd2,
        S_TX   = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [RXW-1:0]     rx_cnt_q,    rx_cnt_d;
    logic [TXW-1:0]     tx_cnt_q,    tx_cnt_d;
    logic [NB_TO-1:0]   to_cnt_q,    to_cnt_d;
    logic               rx_rd_q,     rx_rd_d;
    logic               tx_wr_q,     tx_wr_d;
    logic               err_q,       err_d;
    logic [NB_OP-1:0]   op_sh_q,     op_sh_d;
    logic [NB_AB-1:0]   a_sh_q,      a_sh_d;
    logic [NB_AB-1:0]   b_sh_q,      b_sh_d;
    logic [NB_OP-1:0]   op_q,        op_d;
    logic [NB_AB-1:0]   a_q,         a_d;
    logic [NB_AB-1:0]   b_q,         b_d;
    logic [NB_TXSH-1:0] tx_sh_q,     tx_sh_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;
`ifdef UART_ALU_CHECKSUM_EN
    logic [DBIT-1:0]    chk_q,       chk_d;

    // XOR of all DBIT-wide bytes of a result word.
    function automatic logic [DBIT-1:0] xor_bytes(input logic [NB_AB-1:0] v);
        logic [DBIT-1:0] acc;
        acc = '0;
        for (int i = 0; i < NBYTE; i++) begin
            acc = acc ^ v[i*DBIT +: DBIT];
        end
        return acc;
    endfunction
`endif

    // Next-state and datapath logic for the frame FSM.
    always_comb begin
        state_d     = state_q;
        rx_cnt_d    = rx_cnt_q;
        tx_cnt_d    = tx_cnt_q;
        to_cnt_d    = to_cnt_q;
        rx_rd_d     = 1'b0;
        tx_wr_d     = 1'b0;
        err_d       = 1'b0;
        op_sh_d     = op_sh_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        tx_sh_d     = tx_sh_q;
        frame_cnt_d = frame_cnt_q;
`ifdef UART_ALU_CHECKSUM_EN
        chk_d       = chk_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Every frame starts from clean shadows; this also discards a
                // frame dropped by timeout or checksum error.
                rx_cnt_d = '0;
                to_cnt_d = '0;
                op_sh_d  = '0;
                a_sh_d   = '0;
                b_sh_d   = '0;
`ifdef UART_ALU_CHECKSUM_EN
                chk_d    = '0;
`endif
                if (!rx_empty) begin
                    state_d = S_RX;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RX: begin
                // rx_rd_q blocks a pop in the cycle the FIFO is still retiring
                // the previous word, so pops are never back to back.
                if (!rx_empty && !rx_rd_q) begin
                    rx_rd_d  = 1'b1;
                    to_cnt_d = '0;
                    rx_cnt_d = rx_cnt_q + RXW'(1);
                    if (rx_cnt_q == RXW'(0)) begin
                        op_sh_d = rx_data[NB_OP-1:0];
                    end else if (rx_cnt_q <= RXW'(NBYTE)) begin
                        a_sh_d = (a_sh_q << DBIT) | NB_AB'(rx_data);
                    end else if (rx_cnt_q <= RXW'(2 * NBYTE)) begin
                        b_sh_d = (b_sh_q << DBIT) | NB_AB'(rx_data);
                    end else begin
                        // Trailing checksum byte carries no operand data.
                        op_sh_d = op_sh_q;
                    end
`ifdef UART_ALU_CHECKSUM_EN
                    chk_d = chk_q ^ rx_data;
`endif
                    if (rx_cnt_q == RXW'(NRX - 1)) begin
`ifdef UART_ALU_CHECKSUM_EN
                        if (rx_data != chk_q) begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            op_d    = op_sh_d;
                            a_d     = a_sh_d;
                            b_d     = b_sh_d;
                            state_d = S_EXEC;
                        end
`else
                        // Commit uses the next shadow values so the final
                        // operand byte is included.
                        op_d    = op_sh_d;
                        a_d     = a_sh_d;
                        b_d     = b_sh_d;
                        state_d = S_EXEC;
`endif
                    end else begin
                        state_d = S_RX;
                    end
                end else if (rx_empty) begin
                    if (to_cnt_q == NB_TO'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + NB_TO'(1);
                    end
                end else begin
                    state_d = S_RX;
                end
            end

            S_EXEC: begin
                // Operands were committed on entry; i_result has had this
                // whole cycle to settle.
`ifdef UART_ALU_CHECKSUM_EN
                tx_sh_d = {i_result, xor_bytes(i_result)};
`else
                tx_sh_d = i_result;
`endif
                tx_cnt_d = '0;
                state_d  = S_TX;
            end

            S_TX: begin
                // The byte is retired at the end of its tx_wr cycle; the
                // following cycle re-evaluates tx_full before the next push.
                if (tx_wr_q) begin
                    tx_sh_d  = tx_sh_q << DBIT;
                    tx_cnt_d = tx_cnt_q + TXW'(1);
                    if (tx_cnt_q == TXW'(NTX - 1)) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_TX;
                    end
                end else if (!tx_full) begin
                    tx_wr_d = 1'b1;
                end else begin
                    tx_wr_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            to_cnt_q    <= '0;
            rx_rd_q     <= 1'b0;
            tx_wr_q     <= 1'b0;
            err_q       <= 1'b0;
            op_sh_q     <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tx_sh_q     <= '0;
            frame_cnt_q <= 8'd0;
`ifdef UART_ALU_CHECKSUM_EN
            chk_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
            to_cnt_q    <= to_cnt_d;
            rx_rd_q     <= rx_rd_d;
            tx_wr_q     <= tx_wr_d;
            err_q       <= err_d;
            op_sh_q     <= op_sh_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            tx_sh_q     <= tx_sh_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef UART_ALU_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

    assign rx_rd       = rx_rd_q;
    assign tx_wr       = tx_wr_q;
    assign tx_data     = tx_sh_q[NB_TXSH-1 -: DBIT];
    assign o_op        = op_q;
    assign o_a         = a_q;
    assign o_b         = b_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_frame_err = err_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_frame_ctrl
//
// Directed self-checking bench for uart_alu_frame_ctrl. Models the RX FIFO and
// TX FIFO as queues and the ALU as i_result = o_a + o_b. Honours the
// UART_ALU_CHECKSUM_EN macro for frame layout and the checksum tests.
// -----------------------------------------------------------------------------
module tb_uart_alu_frame_ctrl;

    localparam int DBIT    = 8;
    localparam int NB_OP   = 6;
    localparam int NB_AB   = 16;
    localparam int TIMEOUT = 100;
    localparam int NB_TO   = 16;
`ifdef UART_ALU_CHECKSUM_EN
    localparam int NCHK = 1;
`else
    localparam int NCHK = 0;
`endif
    localparam int NTX = 2 + NCHK;

    logic             clock    = 1'b0;
    logic             reset    = 1'b1;
    logic             rx_empty = 1'b1;
    logic [DBIT-1:0]  rx_data  = 8'h00;
    logic             tx_full  = 1'b0;
    logic             rx_rd;
    logic [DBIT-1:0]  tx_data;
    logic             tx_wr;
    logic [NB_OP-1:0] o_op;
    logic [NB_AB-1:0] o_a;
    logic [NB_AB-1:0] o_b;
    logic [NB_AB-1:0] i_result;
    logic             o_busy;
    logic             o_frame_err;
    logic [7:0]       o_frame_cnt;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   err_cnt     = 0;
    int   consec_viol = 0;
    int   full_viol   = 0;
    logic rx_rd_prev  = 1'b0;

    uart_alu_frame_ctrl #(
        .DBIT(DBIT), .NB_OP(NB_OP), .NB_AB(NB_AB), .TIMEOUT(TIMEOUT), .NB_TO(NB_TO)
    ) dut (
        .clock(clock), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data),
        .rx_rd(rx_rd), .tx_full(tx_full), .tx_data(tx_data), .tx_wr(tx_wr),
        .o_op(o_op), .o_a(o_a), .o_b(o_b), .i_result(i_result), .o_busy(o_busy),
        .o_frame_err(o_frame_err), .o_frame_cnt(o_frame_cnt)
    );

    assign i_result = o_a + o_b;

    always #5 clock = ~clock;

    // FIFO models and protocol monitors, all on the inactive edge.
    always @(negedge clock) begin
        if (rx_rd && rxq.size() > 0) rxq.delete(0);
        if (tx_wr) txq.push_back(tx_data);
        if (rx_rd && rx_rd_prev) consec_viol++;
        if (tx_wr && tx_full) full_viol++;
        if (o_frame_err) err_cnt++;
        rx_rd_prev = rx_rd;
        rx_empty   = (rxq.size() == 0);
        rx_data    = (rxq.size() > 0) ? rxq[0] : 8'h00;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [7:0] bytes [5];
        logic [7:0] x;
        bytes = '{op, a[15:8], a[7:0], b[15:8], b[7:0]};
        x = 8'h00;
        for (int i = 0; i < 5; i++) begin
            rxq.push_back(bytes[i]);
            x = x ^ bytes[i];
        end
`ifdef UART_ALU_CHECKSUM_EN
        rxq.push_back(x);
`endif
    endtask

    task automatic wait_rxq_le(input int n, input string tag);
        int c = 0;
        while (rxq.size() > n && c < 1000) begin
            @(negedge clock);
            c++;
        end
        check_eq({tag, "_rx_drain"}, (rxq.size() <= n) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int c = 0;
        while (txq.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        c = 0;
        while (o_busy && c < 100) begin
            @(negedge clock);
            c++;
        end
        check_eq({tag, "_tx_bytes"}, txq.size(), n);
    endtask

    task automatic pop_tx(output logic [7:0] g);
        if (txq.size() > 0) g = txq.pop_front();
        else g = 8'hxx;
    endtask

    task automatic expect_tx(input logic [15:0] r, input string tag);
        logic [7:0] g;
        pop_tx(g);
        check_eq({tag, "_tx_hi"}, g, r[15:8]);
        pop_tx(g);
        check_eq({tag, "_tx_lo"}, g, r[7:0]);
`ifdef UART_ALU_CHECKSUM_EN
        pop_tx(g);
        check_eq({tag, "_tx_chk"}, g, r[15:8] ^ r[7:0]);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_op"}, o_op, 0);
        check_eq({tag, "_a"}, o_a, 0);
        check_eq({tag, "_b"}, o_b, 0);
        check_eq({tag, "_cnt"}, o_frame_cnt, 0);
        check_eq({tag, "_strobes"}, {o_busy, o_frame_err, rx_rd, tx_wr}, 0);
        check_eq({tag, "_txd"}, tx_data, 0);
    endtask

    initial begin
        int c;
        int e0;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_r[$];

        // Reset values
        repeat (3) @(negedge clock);
        check_all_zero("rst");
        reset = 1'b0;
        @(negedge clock);

        // 1. Basic frame
        push_frame(8'h20, 16'h0102, 16'h0304);
        wait_tx(NTX, 300, "t1");
        expect_tx(16'h0406, "t1");
        check_eq("t1_op", o_op, 6'h20);
        check_eq("t1_a", o_a, 16'h0102);
        check_eq("t1_b", o_b, 16'h0304);
        check_eq("t1_cnt", o_frame_cnt, 1);
        check_eq("t1_busy", o_busy, 0);

        // 2. TX stall while full; opcode upper bits ignored; outputs hold during RX
        tx_full = 1'b1;
        push_frame(8'hE5, 16'h1234, 16'h0102);
        wait_rxq_le(2, "t2");
        check_eq("t2_hold_a", o_a, 16'h0102);
        check_eq("t2_hold_b", o_b, 16'h0304);
        c = 0;
        while (!(o_busy && rxq.size() == 0) && c < 200) begin
            @(negedge clock);
            c++;
        end
        repeat (10) @(negedge clock);
        check_eq("t2_txd_stall_start", tx_data, 8'h13);
        repeat (50) @(negedge clock);
        check_eq("t2_txd_stall_end", tx_data, 8'h13);
        check_eq("t2_no_wr_full", txq.size(), 0);
        tx_full = 1'b0;
        wait_tx(NTX, 300, "t2");
        expect_tx(16'h1336, "t2");
        check_eq("t2_op", o_op, 6'h25);
        check_eq("t2_cnt", o_frame_cnt, 2);
        check_eq("t2_full_viol", full_viol, 0);

        // 3. Inter-byte timeout
        e0 = err_cnt;
        rxq.push_back(8'h20);
        rxq.push_back(8'h01);
        wait_rxq_le(0, "t3");
        c = 0;
        while (err_cnt == e0 && c < 300) begin
            @(negedge clock);
            c++;
        end
        check_eq("t3_err", err_cnt, e0 + 1);
        check_eq("t3_err_latency", (c >= 95 && c <= 110) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(negedge clock);
        check_eq("t3_busy", o_busy, 0);
        check_eq("t3_a", o_a, 16'h1234);
        check_eq("t3_b", o_b, 16'h0102);
        check_eq("t3_op", o_op, 6'h25);
        check_eq("t3_cnt", o_frame_cnt, 2);
        check_eq("t3_no_tx", txq.size(), 0);

        // 4. Reset mid-frame, then a clean frame
        rxq.push_back(8'h20);
        rxq.push_back(8'h01);
        rxq.push_back(8'h02);
        wait_rxq_le(0, "t4");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("t4_rst");
        reset = 1'b0;
        @(negedge clock);
        push_frame(8'h20, 16'h0102, 16'h0304);
        wait_tx(NTX, 300, "t4");
        expect_tx(16'h0406, "t4");
        check_eq("t4_a", o_a, 16'h0102);
        check_eq("t4_cnt", o_frame_cnt, 1);

        // 5. Back-to-back frames, counter wrap
        for (int i = 0; i < 255; i++) begin
            a = 16'(i * 257);
            b = 16'hF00F ^ 16'(i * 7);
            push_frame(8'(i), a, b);
            exp_r.push_back(a + b);
        end
        wait_tx(255 * NTX, 255 * 40, "t5");
        foreach (exp_r[i]) expect_tx(exp_r[i], "t5");
        check_eq("t5_wrap", o_frame_cnt, 0);
        push_frame(8'h01, 16'hFFFF, 16'h0002);
        wait_tx(NTX, 300, "t5b");
        expect_tx(16'h0001, "t5b");
        check_eq("t5_cnt_after_wrap", o_frame_cnt, 1);
        check_eq("t5_no_consec_rd", consec_viol, 0);

`ifdef UART_ALU_CHECKSUM_EN
        // 6. Checksum good and bad
        rxq.push_back(8'h20); rxq.push_back(8'h01); rxq.push_back(8'h02);
        rxq.push_back(8'h03); rxq.push_back(8'h04); rxq.push_back(8'h24);
        wait_tx(3, 300, "t6");
        expect_tx(16'h0406, "t6");
        check_eq("t6_cnt", o_frame_cnt, 2);
        e0 = err_cnt;
        rxq.push_back(8'h20); rxq.push_back(8'h0A); rxq.push_back(8'h0B);
        rxq.push_back(8'h0C); rxq.push_back(8'h0D); rxq.push_back(8'h21);
        c = 0;
        while (err_cnt == e0 && c < 300) begin
            @(negedge clock);
            c++;
        end
        check_eq("t6_chk_err", err_cnt, e0 + 1);
        repeat (10) @(negedge clock);
        check_eq("t6_no_tx", txq.size(), 0);
        check_eq("t6_cnt_hold", o_frame_cnt, 2);
        check_eq("t6_a_hold", o_a, 16'h0102);
        check_eq("t6_busy", o_busy, 0);
`endif

        check_eq("final_full_viol", full_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
